mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if -- bundle of icache, dcache and RAM signals around the
// memory arbiter.
//
//   icache : iREN, iaddr -> arbiter ; iwait, iload <- arbiter
//   dcache : dREN, dWEN, daddr, dstore -> arbiter ; dwait, dload <- arbiter
//   RAM    : ramREN, ramWEN, ramaddr, ramstore <- arbiter ;
//            ramload, ramstate -> arbiter
//
// Modports:
//   slave  : the arbiter's view (requests in, waits/RAM strobes out)
//   master : the surrounding system's view (caches and RAM model)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- single-port RAM arbiter between an icache and a dcache.
//
// The dcache has priority. Each transfer owns the RAM exclusively from the
// grant until RAM reports ACCESS (or the owner drops its request), after
// which the arbiter always passes through IDLE before the next grant.
//
// Ports:
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (icache, dcache and RAM signals)
//
// Parameters:
//   STARVE_LIMIT : consecutive dcache completions tolerated while the icache
//                  waits (only used with ARB_STARVE_GUARD_EN).
//
// Build option:
//   ARB_STARVE_GUARD_EN : when defined, a saturating counter of dcache
//   completions seen while iREN is high forces an icache grant once it
//   reaches STARVE_LIMIT. Undefined: strict dcache priority.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t      state_q, state_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;

  logic        dreq;
  logic        ram_done;

  assign dreq     = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == RAM_ACCESS);

  // Read data is a straight pass-through; it is meaningful only while the
  // owner's wait is low.
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

`ifdef ARB_STARVE_GUARD_EN
  localparam int LIM_W = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W = (LIM_W > 3) ? LIM_W : 3;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starve_hit;

  assign starve_hit = bus.iREN && (starve_q >= LIMIT);
`else
  logic starve_hit;
  logic unused_limit;

  // The limit only matters when the guard is built in.
  assign unused_limit = (STARVE_LIMIT != 0);
  assign starve_hit   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
    end else begin
      state_q    <= state_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  always_comb begin
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.iREN) starve_d = '0;
      end
      DGRANT: begin
        // Count only dcache completions that actually made the icache wait.
        if (dreq && ram_done && bus.iREN && (starve_q != '1))
          starve_d = starve_q + 1'b1;
      end
      IGRANT: begin
        if (bus.iREN && ram_done) starve_d = '0;
      end
      default: starve_d = '0;
    endcase
  end
`endif

  always_comb begin
    state_d      = state_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ramaddr_q;
    bus.ramstore = ramstore_q;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (starve_hit)      state_d = IGRANT;
        else if (dreq)       state_d = DGRANT;
        else if (bus.iREN)   state_d = IGRANT;
      end

      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!dreq) begin
          // Request withdrawn: release the RAM without a completion.
          state_d = IDLE;
        end else begin
          bus.ramWEN = bus.dWEN;
          bus.ramREN = bus.dREN & ~bus.dWEN;
          if (ram_done) begin
            bus.dwait = 1'b0;
            state_d   = IDLE;
          end
        end
      end

      IGRANT: begin
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          if (ram_done) begin
            bus.iwait = 1'b0;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Address/data hold their last driven value while idle.
    ramaddr_d  = bus.ramaddr;
    ramstore_d = bus.ramstore;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic CLK;
  logic nRST;
  int   checks;
  int   failures;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle and land just after the falling edge.
  task automatic next_cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST           = 1'b0;
    bus.iREN       = 1'b0;
    bus.iaddr      = '0;
    bus.dREN       = 1'b0;
    bus.dWEN       = 1'b0;
    bus.daddr      = '0;
    bus.dstore     = '0;
    bus.ramload    = '0;
    bus.ramstate   = FREE;

    // Reset state
    #2;
    chk("rst_ramREN",   32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr",  bus.ramaddr,     32'd0);
    chk("rst_ramstore", bus.ramstore,    32'd0);
    chk("rst_iwait",    32'(bus.iwait),  32'd1);
    chk("rst_dwait",    32'(bus.dwait),  32'd1);
    next_cyc();
    nRST = 1'b1;
    next_cyc();

    // icache read, RAM returns ACCESS immediately
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    settle();
    chk("i1_idle_iwait",  32'(bus.iwait),  32'd1);
    chk("i1_idle_ramREN", 32'(bus.ramREN), 32'd0);
    next_cyc(); settle();
    chk("i1_ramREN",  32'(bus.ramREN), 32'd1);
    chk("i1_ramWEN",  32'(bus.ramWEN), 32'd0);
    chk("i1_ramaddr", bus.ramaddr,     32'h40);
    chk("i1_iwait",   32'(bus.iwait),  32'd0);
    chk("i1_dwait",   32'(bus.dwait),  32'd1);
    chk("i1_iload",   bus.iload,       32'hDEADBEEF);
    next_cyc();
    bus.iREN = 1'b0; settle();
    chk("i1_after_iwait",   32'(bus.iwait),  32'd1);
    chk("i1_after_ramREN",  32'(bus.ramREN), 32'd0);
    chk("i1_after_addr",    bus.ramaddr,     32'h40);

    // dcache write, BUSY three cycles then ACCESS
    next_cyc();
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h12345678; bus.ramstate = BUSY;
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      if (c == 4) bus.ramstate = ACCESS;
      settle();
      chk($sformatf("d2_ramWEN_c%0d", c), 32'(bus.ramWEN), 32'd1);
      chk($sformatf("d2_ramREN_c%0d", c), 32'(bus.ramREN), 32'd0);
      chk($sformatf("d2_dwait_c%0d", c),  32'(bus.dwait),  (c == 4) ? 32'd0 : 32'd1);
    end
    chk("d2_ramaddr",  bus.ramaddr,  32'h100);
    chk("d2_ramstore", bus.ramstore, 32'h12345678);
    next_cyc();
    bus.dWEN = 1'b0; settle();
    chk("d2_idle_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("d2_idle_dwait",  32'(bus.dwait),  32'd1);
    chk("d2_idle_store",  bus.ramstore,    32'h12345678);

    // Simultaneous requests: dcache first, IDLE, then icache
    next_cyc();
    bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.dREN = 1'b1; bus.daddr = 32'h200;
    bus.ramstate = ACCESS; bus.ramload = 32'hA5A5_5A5A;
    next_cyc(); settle();
    chk("p3_d_ramREN",  32'(bus.ramREN), 32'd1);
    chk("p3_d_ramaddr", bus.ramaddr,     32'h200);
    chk("p3_d_dwait",   32'(bus.dwait),  32'd0);
    chk("p3_d_iwait",   32'(bus.iwait),  32'd1);
    chk("p3_d_dload",   bus.dload,       32'hA5A5_5A5A);
    next_cyc();
    bus.dREN = 1'b0; settle();
    chk("p3_idle_ramREN", 32'(bus.ramREN), 32'd0);
    chk("p3_idle_iwait",  32'(bus.iwait),  32'd1);
    next_cyc(); settle();
    chk("p3_i_ramaddr", bus.ramaddr,    32'h300);
    chk("p3_i_iwait",   32'(bus.iwait), 32'd0);
    chk("p3_i_dwait",   32'(bus.dwait), 32'd1);
    next_cyc();
    bus.iREN = 1'b0;

    // dcache read dropped mid-grant
    next_cyc();
    bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = BUSY;
    next_cyc(); settle();
    chk("a4_ramREN", 32'(bus.ramREN), 32'd1);
    chk("a4_dwait",  32'(bus.dwait),  32'd1);
    next_cyc();
    bus.dREN = 1'b0; settle();
    chk("a4_drop_ramREN", 32'(bus.ramREN), 32'd0);
    chk("a4_drop_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("a4_drop_dwait",  32'(bus.dwait),  32'd1);
    next_cyc();
    bus.ramstate = ACCESS; bus.iREN = 1'b1; bus.iaddr = 32'h44; settle();
    chk("a4_idle_dwait",  32'(bus.dwait),  32'd1);
    chk("a4_idle_iwait",  32'(bus.iwait),  32'd1);
    next_cyc(); settle();
    chk("a4_igrant_iwait", 32'(bus.iwait), 32'd0);
    chk("a4_igrant_addr",  bus.ramaddr,    32'h44);
    next_cyc();
    bus.iREN = 1'b0;

    // Read and write together: write wins
    next_cyc();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h500; bus.dstore = 32'hCAFE0001;
    next_cyc(); settle();
    chk("w5_ramWEN", 32'(bus.ramWEN), 32'd1);
    chk("w5_ramREN", 32'(bus.ramREN), 32'd0);
    chk("w5_dwait",  32'(bus.dwait),  32'd0);
    next_cyc();
    bus.dREN = 1'b0; bus.dWEN = 1'b0;

    // Reset pulse during an icache grant
    next_cyc();
    bus.iREN = 1'b1; bus.iaddr = 32'h600; bus.ramstate = BUSY;
    next_cyc(); settle();
    chk("r6_grant_ramREN", 32'(bus.ramREN), 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("r6_rst_ramREN",   32'(bus.ramREN), 32'd0);
    chk("r6_rst_ramaddr",  bus.ramaddr,     32'd0);
    chk("r6_rst_ramstore", bus.ramstore,    32'd0);
    chk("r6_rst_iwait",    32'(bus.iwait),  32'd1);
    next_cyc();
    bus.ramstate = ACCESS;
    nRST = 1'b1; settle();
    chk("r6_rel_iwait",  32'(bus.iwait),  32'd1);
    chk("r6_rel_ramREN", 32'(bus.ramREN), 32'd0);
    next_cyc(); settle();
    chk("r6_regrant_iwait", 32'(bus.iwait), 32'd0);
    next_cyc();
    bus.iREN = 1'b0;

    // Continuous dcache traffic with a waiting icache
    next_cyc();
    bus.iREN = 1'b1; bus.iaddr = 32'h800; bus.dREN = 1'b1; bus.daddr = 32'h700;
    bus.ramstate = ACCESS;
    for (int g = 0; g < 5; g++) begin
      logic exp_i;
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (g == 4);
`else
      exp_i = 1'b0;
`endif
      next_cyc(); settle();
      chk($sformatf("s7_dwait_g%0d", g), 32'(bus.dwait), exp_i ? 32'd1 : 32'd0);
      chk($sformatf("s7_iwait_g%0d", g), 32'(bus.iwait), exp_i ? 32'd0 : 32'd1);
      chk($sformatf("s7_addr_g%0d", g),  bus.ramaddr,    exp_i ? 32'h800 : 32'h700);
      next_cyc(); settle();
      chk($sformatf("s7_idle_g%0d", g), 32'({bus.iwait, bus.dwait}), 32'd3);
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
